// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block width, controller states, default key/IV and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_OUT} state_e;

  localparam logic [AES_BLK_W-1:0] AES_KEY_DEFAULT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [AES_BLK_W-1:0] AES_IV_DEFAULT  = 128'h0f1571c947d9e8590cb7add6af7f6798;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240, inv;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = a15;
    for (int i = 0; i < 4; i++) a240 = gf_mul(a240, a240);
    inv  = gf_mul(gf_mul(a240, a12), a2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aesencrypt.sv
// Combinational AES-128 cipher: on-the-fly key expansion followed by ten unrolled rounds.
module aesencrypt
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] plaintext,
  input  logic [AES_BLK_W-1:0] key,
  output logic [AES_BLK_W-1:0] ciphertext
);

  logic [AES_BLK_W-1:0] rk [11];

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i of the block sits at bits [127-8i -: 8]; state is column-major (i = 4*col + row).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  always_comb begin
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rcon;
    rk[0] = key;
    rcon  = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      {w0, w1, w2, w3} = rk[r-1];
      t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      rk[r] = {w0, w1, w2, w3};
      rcon  = xtime(rcon);
    end
  end

  always_comb begin
    logic [AES_BLK_W-1:0] s;
    s = plaintext ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r != 10) s = mix_columns(s);
      s = s ^ rk[r];
    end
    ciphertext = s;
  end

endmodule

// File: rtl/aes_cbc_encrypt_ctrl.sv
// AES-128 ECB/CBC encryption controller with block counting and sticky completion flag.
// Define CBC_IV_LOAD_EN to add iv_in, which start then loads into the chain instead of IV_DEFAULT.
module aes_cbc_encrypt_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned          NUM_BLOCKS = 65536,
  parameter int unsigned          CORE_LAT   = 1,
  parameter logic [AES_BLK_W-1:0] IV_DEFAULT = AES_IV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef CBC_IV_LOAD_EN
  input  logic [AES_BLK_W-1:0] iv_in,
`endif
  input  logic                 cbc_mode,
  input  logic [AES_BLK_W-1:0] key,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] out_data,
  output logic [31:0]          blk_cnt,
  output logic                 done
);

  localparam logic [31:0] NumBlk   = 32'(NUM_BLOCKS);
  localparam logic [3:0]  WaitInit = 4'(CORE_LAT - 1);

  state_e               state_q, state_d;
  logic [AES_BLK_W-1:0] chain_q, chain_d;
  logic [AES_BLK_W-1:0] core_in_q, core_in_d;
  logic [AES_BLK_W-1:0] out_data_q, out_data_d;
  logic [AES_BLK_W-1:0] core_out, iv_src;
  logic [3:0]           wait_q, wait_d;
  logic [31:0]          blk_cnt_q, blk_cnt_d;
  logic                 mode_q, mode_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;
  logic                 rdy_en_q;

`ifdef CBC_IV_LOAD_EN
  assign iv_src = iv_in;
`else
  assign iv_src = IV_DEFAULT;
`endif

  aesencrypt u_core (
    .plaintext (core_in_q),
    .key       (key),
    .ciphertext(core_out)
  );

  // rdy_en_q holds in_ready low for the first cycle out of reset.
  assign in_ready  = (state_q == S_IDLE) && !done_q && rdy_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign blk_cnt   = blk_cnt_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    chain_d     = chain_q;
    core_in_d   = core_in_q;
    out_data_d  = out_data_q;
    wait_d      = wait_q;
    blk_cnt_d   = blk_cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    done_d      = done_q;
    case (state_q)
      S_IDLE: begin
        // start wins; a coincident input block is left for a later cycle.
        if (start) begin
          chain_d   = iv_src;
          blk_cnt_d = '0;
          done_d    = 1'b0;
        end else if (in_valid && in_ready) begin
          core_in_d = cbc_mode ? (in_data ^ chain_q) : in_data;
          mode_d    = cbc_mode;
          wait_d    = WaitInit;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (wait_q == 4'd0) begin
          out_data_d  = core_out;
          out_valid_d = 1'b1;
          if (mode_q) chain_d = core_out;
          state_d = S_OUT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (blk_cnt_q != NumBlk) blk_cnt_d = blk_cnt_q + 32'd1;
          if (blk_cnt_q + 32'd1 == NumBlk) done_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      chain_q     <= IV_DEFAULT;
      core_in_q   <= '0;
      out_data_q  <= '0;
      wait_q      <= '0;
      blk_cnt_q   <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      chain_q     <= chain_d;
      core_in_q   <= core_in_d;
      out_data_q  <= out_data_d;
      wait_q      <= wait_d;
      blk_cnt_q   <= blk_cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_cbc_encrypt_ctrl.sv
// Bench for aes_cbc_encrypt_ctrl: byte-level AES reference with a chain/count model and inverse cipher.
module tb_aes_cbc_encrypt_ctrl;

  localparam int unsigned NB  = 4;
  localparam int unsigned LAT = 2;
  localparam logic [127:0] IV      = 128'h0f1571c947d9e8590cb7add6af7f6798;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef logic [7:0] ks_t [176];

  logic         clk, reset, start, cbc_mode, in_valid, in_ready, out_valid, out_ready, done;
  logic [127:0] key, in_data, out_data;
  logic [31:0]  blk_cnt;
`ifdef CBC_IV_LOAD_EN
  logic [127:0] iv_in;
`endif

  int unsigned  tests, fails;
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] m_chain;
  int unsigned  m_cnt;
  logic         m_done;

  aes_cbc_encrypt_ctrl #(.NUM_BLOCKS(NB), .CORE_LAT(LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef CBC_IV_LOAD_EN
    .iv_in    (iv_in),
`endif
    .cbc_mode (cbc_mode),
    .key      (key),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .blk_cnt  (blk_cnt),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // S-box from a brute-force field inverse and the bitwise affine equation.
  task automatic build_sbox();
    logic [7:0] inv, o;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++) begin
        o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^
               ((8'h63 >> i) & 8'h01) != 8'h00;
      end
      sb[x] = o;
      isb[o] = 8'(x);
    end
  endtask

  function automatic ks_t expand(input logic [127:0] k);
    ks_t w;
    logic [7:0] t [4];
    logic [7:0] tmp, rc;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tmp  = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[tmp];
        rc   = mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
    end
    return w;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
    ks_t w;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [127:0] o;
    w = expand(k);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(((i/4) + (i%4)) % 4) * 4 + i%4]];
      for (int c = 0; c < 4; c++) begin
        for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
        for (int j = 0; j < 4; j++) begin
          s[4*c+j] = (rnd == 10) ? a[j] :
                     mul(a[j], 8'h02) ^ mul(a[(j+1)%4], 8'h03) ^ a[(j+2)%4] ^ a[(j+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] ct, input logic [127:0] k);
    ks_t w;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [127:0] o;
    w = expand(k);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[160+i];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int i = 0; i < 16; i++) t[i] = isb[s[(((i/4) + 4 - (i%4)) % 4) * 4 + i%4]];
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ w[16*rnd+i];
      for (int c = 0; c < 4; c++) begin
        for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
        for (int j = 0; j < 4; j++) begin
          s[4*c+j] = (rnd == 0) ? a[j] :
                     mul(a[j], 8'h0e) ^ mul(a[(j+1)%4], 8'h0b) ^
                     mul(a[(j+2)%4], 8'h0d) ^ mul(a[(j+3)%4], 8'h09);
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept();
    if (m_cnt < NB) m_cnt++;
    if (m_cnt == NB) m_done = 1'b1;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef CBC_IV_LOAD_EN
    m_chain = iv_in;
`else
    m_chain = IV;
`endif
    m_cnt  = 0;
    m_done = 1'b0;
  endtask

  // Called at a negedge: offers one block, checks latency and ciphertext against the model.
  task automatic xfer(input logic [127:0] p, input logic mode, input string tag,
                      output logic [127:0] got);
    logic [127:0] exp;
    int n;
    exp = enc(mode ? (p ^ m_chain) : p, key);
    in_data  = p;
    cbc_mode = mode;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 128'(in_ready), 128'(1));
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 40);
    check({tag, "_latency"}, 128'(n), 128'(LAT + 1));
    check({tag, "_data"}, out_data, exp);
    got = out_data;
    if (mode) m_chain = exp;
  endtask

  initial begin
    logic [127:0] p0, p1, c0, c1, got, exp;
    logic mode;
    tests = 0;
    fails = 0;
    build_sbox();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; cbc_mode = 1'b0;
    out_ready = 1'b1; key = KAT_KEY;
`ifdef CBC_IV_LOAD_EN
    iv_in = IV;
`endif
    m_chain = IV; m_cnt = 0; m_done = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'h0);
    check("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    reset = 1'b1;
    #1 check("rst_in_ready_first", 128'(in_ready), 128'(0));
    @(negedge clk);
    check("rst_in_ready_after", 128'(in_ready), 128'(1));

    // ECB known answer
    xfer(KAT_PT, 1'b0, "ecb_kat", got);
    accept();
    check("ecb_kat_const", got, KAT_CT);
    @(negedge clk);
    check("ecb_cnt", 128'(blk_cnt), 128'(m_cnt));

    // CBC chaining from IV_DEFAULT, verified by the inverse cipher
    key = IV;
    start_pulse();
    check("cbc_start_cnt", 128'(blk_cnt), 128'(0));
    p0 = rand128();
    p1 = rand128();
    xfer(p0, 1'b1, "cbc0", c0);
    accept();
    xfer(p1, 1'b1, "cbc1", c1);
    accept();
    check("cbc0_decrypt", dec(c0, key) ^ IV, p0);
    check("cbc1_decrypt", dec(c1, key) ^ c0, p1);
    @(negedge clk);
    check("cbc_cnt", 128'(blk_cnt), 128'(m_cnt));

    // Backpressure: ten cycles stalled in the output state
    out_ready = 1'b0;
    p0 = rand128();
    exp = enc(p0, key);
    xfer(p0, 1'b0, "bp", got);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, exp);
      check("bp_hold_valid", 128'(out_valid), 128'(1));
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_cnt_hold", 128'(blk_cnt), 128'(m_cnt));
    end
    out_ready = 1'b1;
    accept();
    @(negedge clk);
    check("bp_release_cnt", 128'(blk_cnt), 128'(m_cnt));
    check("bp_release_valid", 128'(out_valid), 128'(0));

    // Completion: 4th block sets done, 5th is refused
    mode = 1'($urandom);
    xfer(rand128(), mode, "blk4", got);
    accept();
    @(negedge clk);
    check("done_cnt", 128'(blk_cnt), 128'(NB));
    check("done_flag", 128'(done), 128'(m_done));
    in_data  = rand128();
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("blk5_refused", 128'(in_ready), 128'(0));
    end
    check("blk5_cnt", 128'(blk_cnt), 128'(NB));
    check("blk5_no_out", 128'(out_valid), 128'(0));
    in_valid = 1'b0;
    start_pulse();
    check("restart_cnt", 128'(blk_cnt), 128'(0));
    check("restart_done", 128'(done), 128'(0));
    check("restart_ready", 128'(in_ready), 128'(1));

    // Random mixed-mode traffic
    for (int k = 0; k < 3; k++) begin
      mode = 1'($urandom);
      xfer(rand128(), mode, "rand", got);
      accept();
    end
    @(negedge clk);
    check("rand_cnt", 128'(blk_cnt), 128'(m_cnt));

    // Asynchronous reset while a block is in flight
    in_data  = rand128();
    cbc_mode = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_cnt", 128'(blk_cnt), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_chain = IV;
    m_cnt = 0;
    m_done = 1'b0;
    xfer(rand128(), 1'b1, "post_rst", got);
    accept();

`ifdef CBC_IV_LOAD_EN
    iv_in = '0;
    start_pulse();
    p0 = rand128();
    xfer(p0, 1'b1, "ivload", got);
    accept();
    check("ivload_eq_ecb", got, enc(p0, key));
`endif

    @(negedge clk);
    check("final_cnt", 128'(blk_cnt), 128'(m_cnt));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
